// File: rtl/or_result_checker.sv
// ---------------------------------------------------------------------------
// or_result_checker
// Response monitor for an N-bit bitwise OR datapath. Accepts {a, b, result}
// triples over valid/ready, recomputes a|b in a two-stage pipeline, counts
// matches/mismatches, captures the first failing vector and reports pass/fail
// once the programmed number of vectors has been checked.
//
// Optional feature (macro OR_CHK_STOP_ON_FAIL_EN): when defined, the first
// mismatch stops acceptance and the run drains to DONE with pass=0.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             one-cycle run start pulse (honoured in IDLE/DONE only)
//   num_vectors       vectors to check, latched on start
//   in_valid/in_ready handshake for the a/b/result triple
//   a, b, result      operands and DUT result under check
//   busy, done, pass  run status (pass valid while done)
//   match_count       vectors that compared equal
//   mismatch_count    vectors that compared unequal
//   fail_valid        sticky: first-failure fields are valid
//   fail_idx          acceptance index of the first mismatch
//   fail_expected     golden a|b of the first mismatch
//   fail_result       DUT result of the first mismatch
// ---------------------------------------------------------------------------
module or_result_checker #(
    parameter int unsigned N     = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vectors,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic [N-1:0]     result,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] match_count,
    output logic [CNT_W-1:0] mismatch_count,
    output logic             fail_valid,
    output logic [CNT_W-1:0] fail_idx,
    output logic [N-1:0]     fail_expected,
    output logic [N-1:0]     fail_result
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_num;
    logic [CNT_W-1:0] r_acc;
    logic [CNT_W-1:0] r_match;
    logic [CNT_W-1:0] r_mis;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;

    // Stage 1: captured triple awaiting compare
    logic             r_s1_v;
    logic [N-1:0]     r_s1_exp;
    logic [N-1:0]     r_s1_res;
    logic [CNT_W-1:0] r_s1_idx;

    // First-failure capture
    logic             r_fail_valid;
    logic [CNT_W-1:0] r_fail_idx;
    logic [N-1:0]     r_fail_exp;
    logic [N-1:0]     r_fail_res;

    logic             w_ready;
    logic             w_xfer;
    logic             w_s2_match;
    logic             w_s2_mis;
    logic [CNT_W-1:0] w_acc_inc;
    logic             w_last_xfer;
    logic [CNT_W-1:0] w_mis_next;
    logic             w_stop;

    // Ready depends only on state and registers, never on in_valid
    assign w_ready     = (r_state == ST_RUN) && (r_acc < r_num);
    assign w_xfer      = in_valid && w_ready;

    // Stage 2 compare on whatever stage 1 holds this cycle
    assign w_s2_match  = r_s1_v && (r_s1_res == r_s1_exp);
    assign w_s2_mis    = r_s1_v && (r_s1_res != r_s1_exp);

    // r_acc < r_num whenever a transfer happens, so the increment cannot wrap
    assign w_acc_inc   = r_acc + CNT_W'(1);
    assign w_last_xfer = w_xfer && (w_acc_inc == r_num);
    assign w_mis_next  = w_s2_mis ? (r_mis + CNT_W'(1)) : r_mis;

`ifdef OR_CHK_STOP_ON_FAIL_EN
    assign w_stop = w_s2_mis;
`else
    assign w_stop = 1'b0;
`endif

    // Control FSM, pipeline and scoreboard registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_num        <= '0;
            r_acc        <= '0;
            r_match      <= '0;
            r_mis        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_s1_v       <= 1'b0;
            r_s1_exp     <= '0;
            r_s1_res     <= '0;
            r_s1_idx     <= '0;
            r_fail_valid <= 1'b0;
            r_fail_idx   <= '0;
            r_fail_exp   <= '0;
            r_fail_res   <= '0;
        end else begin
            // Stage 1 capture on transfer
            r_s1_v <= w_xfer;
            if (w_xfer) begin
                r_s1_exp <= a | b;
                r_s1_res <= result;
                r_s1_idx <= r_acc;
            end

            // Stage 2 scoreboard update
            if (w_s2_match) begin
                r_match <= r_match + CNT_W'(1);
            end
            if (w_s2_mis) begin
                r_mis <= w_mis_next;
                if (!r_fail_valid) begin
                    r_fail_valid <= 1'b1;
                    r_fail_idx   <= r_s1_idx;
                    r_fail_exp   <= r_s1_exp;
                    r_fail_res   <= r_s1_res;
                end
            end

            case (r_state)
                ST_IDLE, ST_DONE: begin
                    // Stage 1 is empty here, so clearing overrides nothing live
                    if (start) begin
                        r_num        <= num_vectors;
                        r_acc        <= '0;
                        r_match      <= '0;
                        r_mis        <= '0;
                        r_fail_valid <= 1'b0;
                        r_fail_idx   <= '0;
                        r_fail_exp   <= '0;
                        r_fail_res   <= '0;
                        if (num_vectors == '0) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                            r_pass  <= 1'b0;
                        end
                    end
                end

                ST_RUN: begin
                    if (w_xfer) begin
                        r_acc <= w_acc_inc;
                    end
                    if (w_last_xfer || w_stop) begin
                        r_state <= ST_DRAIN;
                    end
                end

                ST_DRAIN: begin
                    // No acceptance in DRAIN: at most one triple sits in stage 1
                    // and it is compared on this edge, leaving both stages empty.
                    r_state <= ST_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_pass  <= (w_mis_next == '0);
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_pass  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready       = w_ready;
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign match_count    = r_match;
    assign mismatch_count = r_mis;
    assign fail_valid     = r_fail_valid;
    assign fail_idx       = r_fail_idx;
    assign fail_expected  = r_fail_exp;
    assign fail_result    = r_fail_res;

endmodule

// File: tb/tb_or_result_checker.sv
// ---------------------------------------------------------------------------
// tb_or_result_checker
// Self-checking bench for or_result_checker: randomized vectors scored by a
// behavioural model (plain loops over the vector table).
// ---------------------------------------------------------------------------
module tb_or_result_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] num_vectors;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  result;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] match_count;
    logic [15:0] mismatch_count;
    logic        fail_valid;
    logic [15:0] fail_idx;
    logic [7:0]  fail_expected;
    logic [7:0]  fail_result;

    int checks = 0;
    int errors = 0;

    logic [7:0] va [64];
    logic [7:0] vb [64];
    logic [7:0] vr [64];

    // Model outputs: two acceptable (match, mismatch) outcomes
    int         m_match_a, m_mis_a, m_match_b, m_mis_b;
    bit         m_fv;
    int         m_fidx;
    logic [7:0] m_fexp, m_fres;
    bit         m_pass;

    or_result_checker #(.N(8), .CNT_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .num_vectors    (num_vectors),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .a              (a),
        .b              (b),
        .result         (result),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .match_count    (match_count),
        .mismatch_count (mismatch_count),
        .fail_valid     (fail_valid),
        .fail_idx       (fail_idx),
        .fail_expected  (fail_expected),
        .fail_result    (fail_result)
    );

    always #5 clk = ~clk;

    task automatic fill_vectors(input int n, input int bad_pct);
        for (int i = 0; i < n; i++) begin
            va[i] = 8'($urandom);
            vb[i] = 8'($urandom);
            vr[i] = va[i] | vb[i];
            if ($urandom_range(99) < bad_pct)
                vr[i] = (va[i] | vb[i]) ^ 8'($urandom_range(255, 1));
        end
    endtask

    task automatic tally(input int upto, output int m, output int mm);
        m = 0;
        mm = 0;
        for (int i = 0; i < upto; i++) begin
            if (vr[i] == (va[i] | vb[i])) m++;
            else mm++;
        end
    endtask

    // Reference: what a run over vectors 0..n-1 must report
    task automatic model_run(input int n);
        m_fv = 1'b0;
        m_fidx = 0;
        m_fexp = 8'h00;
        m_fres = 8'h00;
        for (int i = 0; i < n; i++) begin
            if (!m_fv && vr[i] != (va[i] | vb[i])) begin
                m_fv = 1'b1;
                m_fidx = i;
                m_fexp = va[i] | vb[i];
                m_fres = vr[i];
            end
        end
`ifdef OR_CHK_STOP_ON_FAIL_EN
        if (m_fv) begin
            // The triple accepted alongside the failing compare may or may not be counted
            tally(m_fidx + 1, m_match_a, m_mis_a);
            tally((m_fidx + 2 < n) ? m_fidx + 2 : n, m_match_b, m_mis_b);
        end else begin
            tally(n, m_match_a, m_mis_a);
            tally(n, m_match_b, m_mis_b);
        end
`else
        tally(n, m_match_a, m_mis_a);
        tally(n, m_match_b, m_mis_b);
`endif
        m_pass = !m_fv;
    endtask

    // Runs one start..done sequence; mode 0 continuous, 1 alternate, 2 random gaps
    task automatic drive_run(input int n, input int mode, input bit poke,
                             output int xfers, output int lat, output bit timed_out);
        int idx;
        int cyc;
        int last;
        bit rdy;
        bit v;
        @(negedge clk);
        num_vectors = 16'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        num_vectors = 16'($urandom);
        idx = 0;
        cyc = 0;
        last = 0;
        timed_out = 1'b0;
        while (done !== 1'b1) begin
            if (cyc > 2000) begin
                timed_out = 1'b1;
                break;
            end
            case (mode)
                0:       v = 1'b1;
                1:       v = ((cyc % 2) == 0);
                default: v = ($urandom_range(99) >= 30);
            endcase
            in_valid = v;
            if (idx < n && idx < 64) begin
                a = va[idx];
                b = vb[idx];
                result = vr[idx];
            end else begin
                a = 8'($urandom);
                b = 8'($urandom);
                result = 8'($urandom);
            end
            start = poke && ($urandom_range(7) == 0);
            num_vectors = 16'd5;
            #1 rdy = in_ready;
            @(posedge clk);
            if (v && rdy) begin
                idx++;
                last = cyc;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        xfers = idx;
        lat = cyc - last;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        num_vectors = 16'd0;
        a = 8'h00;
        b = 8'h00;
        result = 8'h00;
        #1;
        checks++;
        if ({in_ready, busy, done, pass, fail_valid} !== 5'b0 || match_count !== 16'd0 ||
            mismatch_count !== 16'd0 || fail_idx !== 16'd0 || fail_expected !== 8'h00 ||
            fail_result !== 8'h00) begin
            errors++;
            $display("FAIL reset_hold: flags=%b mc=%0d mm=%0d required all zero",
                     {in_ready, busy, done, pass, fail_valid}, match_count, mismatch_count);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready, busy, done, pass, fail_valid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_idle: flags=%b required 00000", {in_ready, busy, done, pass, fail_valid});
        end
    endtask

    task automatic test_single();
        int xf, lat;
        bit to;
        va[0] = 8'h96;
        vb[0] = 8'hAA;
        vr[0] = 8'hBE;
        drive_run(1, 0, 1'b0, xf, lat, to);
        checks++;
        if (to || done !== 1'b1 || pass !== 1'b1) begin
            errors++;
            $display("FAIL single_done: timeout=%0d done=%b pass=%b required 0 1 1", to, done, pass);
        end
        checks++;
        if (match_count !== 16'd1 || mismatch_count !== 16'd0 || fail_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_counts: mc=%0d mm=%0d fv=%b required 1 0 0",
                     match_count, mismatch_count, fail_valid);
        end
    endtask

    task automatic test_corrupt();
        int xf, lat;
        bit to;
        fill_vectors(4, 0);
        va[2] = 8'h96;
        vb[2] = 8'hAA;
        vr[2] = 8'hBC;
        model_run(4);
        drive_run(4, 0, 1'b0, xf, lat, to);
        checks++;
        if (to || done !== 1'b1 || pass !== 1'b0) begin
            errors++;
            $display("FAIL corrupt_done: timeout=%0d done=%b pass=%b required 0 1 0", to, done, pass);
        end
        checks++;
        if (!((match_count == 16'(m_match_a) && mismatch_count == 16'(m_mis_a)) ||
              (match_count == 16'(m_match_b) && mismatch_count == 16'(m_mis_b)))) begin
            errors++;
            $display("FAIL corrupt_counts: mc=%0d mm=%0d required %0d/%0d", match_count,
                     mismatch_count, m_match_b, m_mis_b);
        end
        checks++;
        if (fail_valid !== 1'b1 || fail_idx !== 16'd2 || fail_expected !== 8'hBE ||
            fail_result !== 8'hBC) begin
            errors++;
            $display("FAIL corrupt_capture: fv=%b idx=%0d exp=%h res=%h required 1 2 be bc",
                     fail_valid, fail_idx, fail_expected, fail_result);
        end
    endtask

    task automatic test_stall();
        int xf, lat;
        bit to;
        fill_vectors(8, 0);
        model_run(8);
        drive_run(8, 1, 1'b0, xf, lat, to);
        checks++;
        if (to || match_count !== 16'd8 || mismatch_count !== 16'd0 || pass !== 1'b1) begin
            errors++;
            $display("FAIL stall_counts: timeout=%0d mc=%0d mm=%0d pass=%b required 0 8 0 1",
                     to, match_count, mismatch_count, pass);
        end
        checks++;
        if (xf != 8) begin
            errors++;
            $display("FAIL stall_xfers: got %0d transfers required 8", xf);
        end
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL stall_latency: done %0d cycles after last transfer required 2", lat);
        end
    endtask

    task automatic test_back_to_back();
        int xf, lat;
        bit to;
        fill_vectors(12, 0);
        model_run(12);
        drive_run(12, 0, 1'b0, xf, lat, to);
        checks++;
        if (to || match_count !== 16'(m_match_a) || mismatch_count !== 16'd0 || xf != 12 || lat != 2) begin
            errors++;
            $display("FAIL b2b: timeout=%0d mc=%0d xfers=%0d lat=%0d required 0 %0d 12 2",
                     to, match_count, xf, lat, m_match_a);
        end
    endtask

    task automatic test_zero_restart();
        int xf, lat;
        bit to;
        @(negedge clk);
        num_vectors = 16'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: done=%b pass=%b busy=%b required 1 1 0", done, pass, busy);
        end
        checks++;
        if (match_count !== 16'd0 || mismatch_count !== 16'd0 || fail_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_cleared: mc=%0d mm=%0d fv=%b required 0 0 0",
                     match_count, mismatch_count, fail_valid);
        end
        fill_vectors(3, 0);
        vr[1] = vr[1] ^ 8'h10;
        model_run(3);
        drive_run(3, 2, 1'b1, xf, lat, to);
        checks++;
        if (to || !((match_count == 16'(m_match_a) && mismatch_count == 16'(m_mis_a)) ||
                    (match_count == 16'(m_match_b) && mismatch_count == 16'(m_mis_b)))) begin
            errors++;
            $display("FAIL restart_counts: timeout=%0d mc=%0d mm=%0d required %0d/%0d",
                     to, match_count, mismatch_count, m_match_a, m_mis_a);
        end
        checks++;
        if (fail_idx !== 16'd1 || fail_result !== m_fres || pass !== 1'b0) begin
            errors++;
            $display("FAIL restart_capture: idx=%0d res=%h pass=%b required 1 %h 0",
                     fail_idx, fail_result, pass, m_fres);
        end
`ifndef OR_CHK_STOP_ON_FAIL_EN
        checks++;
        if (xf != 3) begin
            errors++;
            $display("FAIL restart_ignore_start: got %0d transfers required 3", xf);
        end
`endif
    endtask

    task automatic test_reset_mid_run();
        int idx;
        int cyc;
        bit rdy;
        int xf, lat;
        bit to;
        fill_vectors(10, 0);
        @(negedge clk);
        num_vectors = 16'd10;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < 5 && cyc < 100) begin
            in_valid = 1'b1;
            a = va[idx];
            b = vb[idx];
            result = vr[idx];
            #1 rdy = in_ready;
            @(posedge clk);
            if (rdy) idx++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (idx != 5 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midrun_progress: transfers=%0d busy=%b required 5 1", idx, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, busy, done, pass, fail_valid} !== 5'b0 || match_count !== 16'd0 ||
            mismatch_count !== 16'd0) begin
            errors++;
            $display("FAIL midrun_async_reset: flags=%b mc=%0d mm=%0d required all zero",
                     {in_ready, busy, done, pass, fail_valid}, match_count, mismatch_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        fill_vectors(2, 0);
        drive_run(2, 2, 1'b0, xf, lat, to);
        checks++;
        if (to || match_count !== 16'd2 || mismatch_count !== 16'd0 || pass !== 1'b1) begin
            errors++;
            $display("FAIL midrun_fresh_run: timeout=%0d mc=%0d mm=%0d pass=%b required 0 2 0 1",
                     to, match_count, mismatch_count, pass);
        end
    endtask

    task automatic test_random();
        int xf, lat;
        bit to;
        for (int r = 0; r < 4; r++) begin
            fill_vectors(20, 25);
            model_run(20);
            drive_run(20, 2, 1'b1, xf, lat, to);
            checks++;
            if (to || !((match_count == 16'(m_match_a) && mismatch_count == 16'(m_mis_a)) ||
                        (match_count == 16'(m_match_b) && mismatch_count == 16'(m_mis_b)))) begin
                errors++;
                $display("FAIL random_counts[%0d]: timeout=%0d mc=%0d mm=%0d required %0d/%0d",
                         r, to, match_count, mismatch_count, m_match_a, m_mis_a);
            end
            checks++;
            if (pass !== m_pass || fail_valid !== m_fv ||
                (m_fv && (fail_idx !== 16'(m_fidx) || fail_expected !== m_fexp || fail_result !== m_fres))) begin
                errors++;
                $display("FAIL random_capture[%0d]: pass=%b fv=%b idx=%0d exp=%h res=%h required %b %b %0d %h %h",
                         r, pass, fail_valid, fail_idx, fail_expected, fail_result,
                         m_pass, m_fv, m_fidx, m_fexp, m_fres);
            end
        end
    endtask

`ifdef OR_CHK_STOP_ON_FAIL_EN
    task automatic test_stop_on_fail();
        int xf, lat;
        bit to;
        fill_vectors(10, 0);
        va[3] = 8'h96;
        vb[3] = 8'hAA;
        vr[3] = 8'hBC;
        drive_run(10, 0, 1'b0, xf, lat, to);
        checks++;
        if (to || done !== 1'b1 || pass !== 1'b0 || mismatch_count !== 16'd1 || fail_idx !== 16'd3) begin
            errors++;
            $display("FAIL stop_result: timeout=%0d done=%b pass=%b mm=%0d idx=%0d required 0 1 0 1 3",
                     to, done, pass, mismatch_count, fail_idx);
        end
        checks++;
        if (match_count > 16'd4 || match_count < 16'd3 || xf >= 10) begin
            errors++;
            $display("FAIL stop_early: mc=%0d xfers=%0d required mc in 3..4 and xfers<10",
                     match_count, xf);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_corrupt();
        test_stall();
        test_back_to_back();
        test_zero_restart();
        test_reset_mid_run();
        test_random();
`ifdef OR_CHK_STOP_ON_FAIL_EN
        test_stop_on_fail();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/or_result_checker.md
Name: or_result_checker

Overview:
- Self-checking response monitor for the N-bit bitwise OR operator; sits on the consumer side of the OR datapath, opposite the stimulus source.
- Accepts {a, b, result} triples over a valid/ready handshake and recomputes a|b as the golden value in a 2-stage pipeline.
- Counts matches and mismatches and captures the first failing vector.
- Reports pass/fail once a programmed number of vectors has been checked.

Parameters:
- N, 8, operand/result width in bits.
- CNT_W, 16, width of the vector count, the counters and the index registers.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; begins a run; sampled only in IDLE or DONE.
- num_vectors  in  CNT_W  vectors to check; sampled on start.
- in_valid  in  1  triple on a/b/result is valid.
- in_ready  out  1  checker can accept a triple.
- a  in  N  operand A.
- b  in  N  operand B.
- result  in  N  DUT output under check.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE.
- pass  out  1  valid while done; 1 iff mismatch_count==0.
- match_count  out  CNT_W  vectors that compared equal.
- mismatch_count  out  CNT_W  vectors that compared unequal.
- fail_valid  out  1  sticky; first-failure fields are valid.
- fail_idx  out  CNT_W  0-based acceptance index of the first mismatch.
- fail_expected  out  N  golden a|b of the first mismatch.
- fail_result  out  N  DUT result of the first mismatch.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0: in_ready, busy, done, pass, both counters, fail_valid, fail_idx, fail_expected, fail_result. Pipeline valid bits cleared. Reset mid-run aborts immediately; no partial result is retained.
- States:
  - IDLE -> RUN on start (num_vectors!=0).
  - IDLE -> DONE on start with num_vectors==0; pass=1, counters 0.
  - RUN -> DRAIN when accepted count reaches num_vectors.
  - DRAIN -> DONE when both pipeline stages are empty.
  - DONE -> RUN or DONE on start, same rules as from IDLE.
  - start in RUN or DRAIN is ignored.
- On start: counters, fail_valid, fail fields and accepted index cleared; num_vectors latched.
- Handshake:
  - in_ready = (state==RUN) && (accepted < num_vectors_latched); combinational from state and registers only, never from in_valid.
  - Transfer occurs on a cycle with in_valid && in_ready. a, b and result may change freely when no transfer occurs.
  - One transfer per cycle max; back-to-back transfers at full rate.
- Pipeline:
  - Stage 1, edge of transfer: register result, expected=a|b, and index.
  - Stage 2, next edge: compare. Match: match_count+1. Mismatch: mismatch_count+1, and if fail_valid==0 then set fail_valid and capture fail_idx, fail_expected, fail_result.
  - Counters are visible 2 cycles after the transfer cycle.
- Arithmetic: the compare is full N-bit equality. Counters never exceed num_vectors, so no wrap or saturation logic is needed. match_count + mismatch_count == num_vectors in DONE.
- done asserts the cycle after the last stage-2 update. pass = done && (mismatch_count==0), held until the next start or reset.
- Gaps on in_valid in RUN just stall; the pipeline still drains and the counters stay correct.

Optional Feature:
- Macro OR_CHK_STOP_ON_FAIL_EN.
- Defined:
  - On the first mismatch's stage-2 update, in_ready drops in the same edge's next cycle and state moves RUN -> DRAIN.
  - Any triple already in stage 1 is still compared and counted.
  - done then asserts with pass=0; match_count + mismatch_count may be < num_vectors.
- Undefined: all num_vectors vectors are always checked regardless of failures.

Test Plan:
- Single vector: num_vectors=1, a=8'h96, b=8'hAA, result=8'hBE -> done, pass=1, match_count=1, mismatch_count=0, fail_valid=0.
- Corrupted vector: 4 vectors, the third (idx 2) with a=8'h96, b=8'hAA, result=8'hBC -> mismatch_count=1, match_count=3, fail_idx=2, fail_expected=8'hBE, fail_result=8'hBC, pass=0.
- Backpressure/stall: 8 vectors with in_valid toggled every other cycle, then extra in_valid after the 8th -> in_ready=0 after the 8th transfer, exactly 8 counted, done ~2 cycles after the last transfer.
- Zero count and restart: start with num_vectors=0 -> done, pass=1 next cycle. Then start with 3 vectors -> counters cleared before new counts. start pulses during RUN -> ignored.
- Reset mid-run: rst_n low after 5 of 10 transfers -> all outputs 0 asynchronously, state IDLE. A fresh 2-vector run then gives match_count=2.
- OR_CHK_STOP_ON_FAIL_EN defined: 10 vectors, idx 3 bad, continuous valid -> acceptance stops; done with pass=0, mismatch_count=1, fail_idx=3, match_count <=4 (in-flight vector still counted).
